// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the MAC accumulate stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Accumulator width: result width plus guard bits.
  function automatic int acc_width(input int n, input int g);
    return n + g;
  endfunction

  // Largest positive N-bit two's complement value.
  function automatic int sat_max(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  // Most negative N-bit two's complement value.
  function automatic int sat_min(input int n);
    return -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/mac_sat_narrow.sv
// Narrows the guard-extended accumulator to N bits and flags overflow.
// Latency: combinational.
// Backpressure: none. MAC_ACC_SATURATE_EN selects clamping, else truncation.
module mac_sat_narrow
  import mac_acc_pkg::*;
#(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic [N+G-1:0] acc_i,
  output logic [N-1:0]   res_o,
  output logic           ovf_o
);

  localparam int ACC_W = acc_width(N, G);

  logic [G:0] upper;

`ifdef MAC_ACC_SATURATE_EN
  localparam logic [N-1:0] SAT_MAX = N'(sat_max(N));
  localparam logic [N-1:0] SAT_MIN = N'(sat_min(N));
`endif

  // Value fits in N bits only when the top G+1 bits are all sign copies.
  always_comb begin
    upper = acc_i[ACC_W-1:N-1];
    ovf_o = ~((&upper) | ~(|upper));
`ifdef MAC_ACC_SATURATE_EN
    if (ovf_o) begin
      res_o = acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      res_o = acc_i[N-1:0];
    end
`else
    res_o = acc_i[N-1:0];
`endif
  end

endmodule

// File: rtl/mac_accumulate.sv
// Sums a stream of signed products onto a bias; emits the narrowed dot product on the last beat.
// Latency: acc_valid_o rises the cycle after the last beat is accepted.
// Backpressure: prod_ready_o low while a result waits in DONE; no bypass. Optional: MAC_ACC_SATURATE_EN.
module mac_accumulate
  import mac_acc_pkg::*;
#(
  parameter int N     = 8,
  parameter int G     = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     prod_i,
  input  logic             prod_valid_i,
  input  logic             prod_last_i,
  output logic             prod_ready_o,
  input  logic [N-1:0]     bias_i,
  output logic [N-1:0]     acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [LEN_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int ACC_W = acc_width(N, G);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       res_q, res_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   count_q, count_d;

  logic               beat_acc;
  logic [ACC_W-1:0]   prod_sext;
  logic [ACC_W-1:0]   bias_sext;
  logic [ACC_W-1:0]   sum;
  logic [LEN_W-1:0]   cnt_new;
  logic [N-1:0]       res_n;
  logic               ovf_n;

  assign beat_acc = prod_valid_i & prod_ready_o;

  // Narrow the post-beat sum so the result registers load on the last beat's edge.
  mac_sat_narrow #(.N(N), .G(G)) u_narrow (
    .acc_i (sum),
    .res_o (res_n),
    .ovf_o (ovf_n)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a last beat closes the vector; the consumer's accept reopens it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat_acc) state_d = prod_last_i ? DONE : ACC;
      ACC:     if (beat_acc && prod_last_i) state_d = DONE;
      DONE:    if (acc_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes are pure functions of state.
  always_comb begin
    prod_ready_o = (state_q != DONE);
    acc_valid_o  = (state_q == DONE);
  end

  // Datapath: seed with bias on the first beat, saturating beat counter, result capture.
  always_comb begin
    prod_sext = {{G{prod_i[N-1]}}, prod_i};
    bias_sext = {{G{bias_i[N-1]}}, bias_i};
    if (state_q == IDLE) begin
      sum     = bias_sext + prod_sext;
      cnt_new = LEN_W'(1);
    end else begin
      sum     = acc_q + prod_sext;
      cnt_new = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
    end
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (beat_acc) begin
      acc_d = sum;
      cnt_d = cnt_new;
      if (prod_last_i) begin
        res_d   = res_n;
        ovf_d   = ovf_n;
        count_d = cnt_new;
      end
    end
  end

  // Accumulator, counter and result registers; reset drops any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign acc_o   = res_q;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// Bench for mac_accumulate (N=8, G=4, LEN_W=8); expectations follow MAC_ACC_SATURATE_EN.
// Inputs driven on the falling edge; results scoreboarded at the output handshake.
// Multi-cycle cases: backpressure in DONE, mid-vector reset, counter saturation.
module tb_mac_accumulate;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] prod_i;
  logic       prod_valid_i;
  logic       prod_last_i;
  logic       prod_ready_o;
  logic [7:0] bias_i;
  logic [7:0] acc_o;
  logic       acc_valid_o;
  logic       acc_ready_i;
  logic [7:0] count_o;
  logic       ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] acc;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [7:0]      bias;
    logic [2:0]      n;
    logic [3:0][7:0] prods;
    logic [7:0]      exp_trunc;
    logic [7:0]      exp_sat;
    logic [7:0]      cnt;
    logic            ovf;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  mac_accumulate #(.N(8), .G(4), .LEN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .prod_last_i  (prod_last_i),
    .prod_ready_o (prod_ready_o),
    .bias_i       (bias_i),
    .acc_o        (acc_o),
    .acc_valid_o  (acc_valid_o),
    .acc_ready_i  (acc_ready_i),
    .count_o      (count_o),
    .ovf_o        (ovf_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] b, input logic [2:0] n,
                         input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3,
                         input logic [7:0] et, input logic [7:0] es,
                         input logic [7:0] c, input logic o);
    tbl[i].bias      = b;
    tbl[i].n         = n;
    tbl[i].prods[0]  = p0;
    tbl[i].prods[1]  = p1;
    tbl[i].prods[2]  = p2;
    tbl[i].prods[3]  = p3;
    tbl[i].exp_trunc = et;
    tbl[i].exp_sat   = es;
    tbl[i].cnt       = c;
    tbl[i].ovf       = o;
  endtask

  function automatic exp_t mk_exp(input logic [7:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.ovf = o;
    return e;
  endfunction

  // Present a beat at the falling edge; returns once it will be taken at the next rising edge.
  task automatic send_beat(input logic [7:0] b, input logic [7:0] p, input logic last);
    int waited;
    waited = 0;
    @(negedge clk);
    prod_valid_i = 1'b1;
    prod_i       = p;
    bias_i       = b;
    prod_last_i  = last;
    while (!prod_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("beat_ready", {31'd0, prod_ready_o}, 32'd1);
  endtask

  // Scoreboard: compare whenever the consumer takes a result.
  always @(negedge clk) begin
    #1;
    if (!rst && acc_valid_o && acc_ready_i) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_acc", {24'd0, acc_o}, {24'd0, e.acc});
        check("sb_count", {24'd0, count_o}, {24'd0, e.cnt});
        check("sb_ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    logic [7:0] exp_acc;
    int waited;

    set_vec(0, 8'h05, 3'd1, 8'h03, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'd1, 1'b0);
    set_vec(1, 8'h05, 3'd2, 8'h03, 8'hF6, 8'h00, 8'h00, 8'hFE, 8'hFE, 8'd2, 1'b0);
    set_vec(2, 8'h00, 3'd3, 8'h64, 8'h64, 8'h64, 8'h00, 8'h2C, 8'h7F, 8'd3, 1'b1);
    set_vec(3, 8'h80, 3'd1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'd1, 1'b1);
    set_vec(4, 8'h7F, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'd1, 1'b0);
    set_vec(5, 8'hFF, 3'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFB, 8'd4, 1'b0);
    set_vec(6, 8'h80, 3'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h80, 8'd1, 1'b1);
    set_vec(7, 8'h7F, 3'd1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h7F, 8'd1, 1'b1);

    rst          = 1'b1;
    prod_i       = '0;
    prod_valid_i = 1'b0;
    prod_last_i  = 1'b0;
    bias_i       = '0;
    acc_ready_i  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_acc", {24'd0, acc_o}, 32'd0);
    check("rst_count", {24'd0, count_o}, 32'd0);
    check("rst_ovf", {31'd0, ovf_o}, 32'd0);
    check("rst_valid", {31'd0, acc_valid_o}, 32'd0);
    check("rst_ready", {31'd0, prod_ready_o}, 32'd1);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
`ifdef MAC_ACC_SATURATE_EN
      exp_acc = tbl[i].exp_sat;
`else
      exp_acc = tbl[i].exp_trunc;
`endif
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        send_beat(tbl[i].bias, tbl[i].prods[k], (k == int'(tbl[i].n) - 1));
      end
      sbq.push_back(mk_exp(exp_acc, tbl[i].cnt, tbl[i].ovf));
      @(negedge clk);
      prod_valid_i = 1'b0;
      check("latency_valid", {31'd0, acc_valid_o}, 32'd1);
    end

    // Backpressure: result held in DONE while a new beat waits.
    @(negedge clk);
    acc_ready_i = 1'b0;
    send_beat(8'h02, 8'h07, 1'b1);
    sbq.push_back(mk_exp(8'h09, 8'd1, 1'b0));
    @(negedge clk);
    prod_valid_i = 1'b1;
    prod_i       = 8'h01;
    bias_i       = 8'h01;
    prod_last_i  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("bp_ready_low", {31'd0, prod_ready_o}, 32'd0);
      check("bp_valid", {31'd0, acc_valid_o}, 32'd1);
      check("bp_acc_stable", {24'd0, acc_o}, 32'h09);
      check("bp_count_stable", {24'd0, count_o}, 32'd1);
      @(negedge clk);
    end
    acc_ready_i = 1'b1;
    check("bp_no_bypass", {31'd0, prod_ready_o}, 32'd0);
    @(negedge clk);
    check("bp_idle_valid", {31'd0, acc_valid_o}, 32'd0);
    check("bp_idle_ready", {31'd0, prod_ready_o}, 32'd1);
    sbq.push_back(mk_exp(8'h02, 8'd1, 1'b0));
    @(negedge clk);
    prod_valid_i = 1'b0;
    check("bp_pending_done", {31'd0, acc_valid_o}, 32'd1);

    // Reset after two of four beats.
    send_beat(8'h0A, 8'h0A, 1'b0);
    send_beat(8'h0A, 8'h14, 1'b0);
    @(negedge clk);
    prod_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_acc", {24'd0, acc_o}, 32'd0);
    check("arst_count", {24'd0, count_o}, 32'd0);
    check("arst_ovf", {31'd0, ovf_o}, 32'd0);
    check("arst_valid", {31'd0, acc_valid_o}, 32'd0);
    check("arst_ready", {31'd0, prod_ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send_beat(8'h01, 8'h01, 1'b1);
    sbq.push_back(mk_exp(8'h02, 8'd1, 1'b0));
    @(negedge clk);
    prod_valid_i = 1'b0;
    check("post_rst_valid", {31'd0, acc_valid_o}, 32'd1);

    // Beat counter saturates at 255 over a 300-beat vector.
    for (int k = 0; k < 300; k++) begin
      send_beat(8'h00, 8'h00, (k == 299));
    end
    sbq.push_back(mk_exp(8'h00, 8'd255, 1'b0));
    @(negedge clk);
    prod_valid_i = 1'b0;
    check("sat_cnt_valid", {31'd0, acc_valid_o}, 32'd1);

    waited = 0;
    while (sbq.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("sb_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
